// File: rtl/sprite_grid_ctrl.sv
// sprite_grid_ctrl
//   Maps the raster position onto a COLS x ROWS grid of sprite cells and
//   produces the sprite ROM address and palette select for the current pixel.
//   All outputs are registered and lag DrawX/DrawY/blank by one vga_clk cycle.
// Ports:
//   vga_clk, reset_n   pixel clock, synchronous active-low reset
//   DrawX, DrawY       current raster position
//   blank              1 = active video
//   pattern            step-on bits, index row*COLS + col
//   playhead           highlighted step column (>= COLS highlights nothing)
//   rom_address        ly*SPR + lx inside a sprite, else 0
//   sprite_sel         {playhead column hit, step-on bit}, 0 outside sprites
//   in_cell            pixel lies inside a sprite
//   blank_out          blank delayed by one cycle
module sprite_grid_ctrl #(
    parameter int X0    = 40,
    parameter int Y0    = 100,
    parameter int COLS  = 16,
    parameter int ROWS  = 4,
    parameter int PITCH = 36,
    parameter int SPR   = 35
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   blank,
    input  logic [ROWS*COLS-1:0]   pattern,
    input  logic [3:0]             playhead,
    output logic [10:0]            rom_address,
    output logic [1:0]             sprite_sel,
    output logic                   in_cell,
    output logic                   blank_out
);

    localparam int LW = (PITCH > 1) ? $clog2(PITCH) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

    logic [LW-1:0]        lx, ly, lx_n, ly_n;
    logic [CW-1:0]        col, col_n;
    logic [RW-1:0]        row, row_n;
    logic                 hact, vact, hact_n, vact_n;
    logic [ROWS*COLS-1:0] shadow_pattern;
    logic [3:0]           shadow_playhead;
    logic                 cell_hit;
    logic [PW-1:0]        bit_idx;
    logic [10:0]          addr_n;
    logic                 col_hl;

    // The *_n values describe the pixel presented this cycle; they become
    // both the tracking state and the registered outputs at the same edge,
    // which is what gives the single cycle of latency.
    always_comb begin
        lx_n   = lx;
        col_n  = col;
        hact_n = hact;
        ly_n   = ly;
        row_n  = row;
        vact_n = vact;

        if (DrawX == 10'(X0)) begin
            lx_n   = '0;
            col_n  = '0;
            hact_n = 1'b1;
        end else if (hact && lx == LW'(PITCH - 1) && col == CW'(COLS - 1)) begin
            hact_n = 1'b0;
        end else if (hact && lx == LW'(PITCH - 1)) begin
            lx_n  = '0;
            col_n = col + 1'b1;
        end else if (hact) begin
            lx_n = lx + 1'b1;
        end

        // Vertical state steps once per line, at the grid's left edge, using
        // that line's own DrawY.
        if (DrawX == 10'(X0)) begin
            if (DrawY == 10'(Y0)) begin
                ly_n   = '0;
                row_n  = '0;
                vact_n = 1'b1;
            end else if (vact && ly == LW'(PITCH - 1) && row == RW'(ROWS - 1)) begin
                vact_n = 1'b0;
            end else if (vact && ly == LW'(PITCH - 1)) begin
                ly_n  = '0;
                row_n = row + 1'b1;
            end else if (vact) begin
                ly_n = ly + 1'b1;
            end
        end

        cell_hit = blank && hact_n && vact_n && (lx_n < LW'(SPR)) && (ly_n < LW'(SPR));
        bit_idx  = PW'(row_n) * PW'(COLS) + PW'(col_n);
        addr_n   = 11'(ly_n) * 11'(SPR) + 11'(lx_n);
        // Wide compare so an out-of-range playhead matches no column.
        col_hl   = (32'(col_n) == 32'(shadow_playhead));
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            lx              <= '0;
            ly              <= '0;
            col             <= '0;
            row             <= '0;
            hact            <= 1'b0;
            vact            <= 1'b0;
            shadow_pattern  <= '0;
            shadow_playhead <= '0;
            rom_address     <= '0;
            sprite_sel      <= '0;
            in_cell         <= 1'b0;
            blank_out       <= 1'b0;
        end else begin
            lx   <= lx_n;
            ly   <= ly_n;
            col  <= col_n;
            row  <= row_n;
            hact <= hact_n;
            vact <= vact_n;

            // Latch during vertical blanking so a frame never shows a torn grid.
            if (DrawX == 10'd0 && DrawY == 10'd480) begin
                shadow_pattern  <= pattern;
                shadow_playhead <= playhead;
            end

            in_cell     <= cell_hit;
            rom_address <= cell_hit ? addr_n : '0;
            sprite_sel  <= cell_hit ? {col_hl, shadow_pattern[bit_idx]} : 2'b00;
            blank_out   <= blank;
        end
    end

endmodule

// File: tb/tb_sprite_grid_ctrl.sv
module tb_sprite_grid_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [63:0] pattern;
    logic [3:0]  playhead;
    logic [10:0] rom_address, rom_address8;
    logic [1:0]  sprite_sel, sprite_sel8;
    logic        in_cell, in_cell8;
    logic        blank_out, blank_out8;

    int total = 0;
    int bad   = 0;

    logic        ic_a  [0:639];
    logic [10:0] ra_a  [0:639];
    logic [1:0]  ss_a  [0:639];
    logic        bo_a  [0:639];
    logic        ic8_a [0:639];
    logic [1:0]  ss8_a [0:639];

    always #5 vga_clk = ~vga_clk;

    sprite_grid_ctrl dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .pattern(pattern), .playhead(playhead),
        .rom_address(rom_address), .sprite_sel(sprite_sel),
        .in_cell(in_cell), .blank_out(blank_out)
    );

    sprite_grid_ctrl #(.COLS(8)) dut8 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .pattern(pattern[31:0]), .playhead(playhead),
        .rom_address(rom_address8), .sprite_sel(sprite_sel8),
        .in_cell(in_cell8), .blank_out(blank_out8)
    );

    // Present one pixel; on return the outputs describe that pixel.
    task automatic step(input int x, input int y);
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge vga_clk);
        #1;
    endtask

    task automatic fast_lines(input int y0, input int y1);
        for (int y = y0; y < y1; y++) step(40, y);
    endtask

    task automatic run_line(input int y);
        for (int x = 40; x <= 620; x++) begin
            step(x, y);
            ic_a[x]  = in_cell;
            ra_a[x]  = rom_address;
            ss_a[x]  = sprite_sel;
            bo_a[x]  = blank_out;
            ic8_a[x] = in_cell8;
            ss8_a[x] = sprite_sel8;
        end
    endtask

    task automatic frame_to(input int y);
        fast_lines(100, y);
        run_line(y);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; blank = 1'b1; pattern = '1; playhead = 4'd0;
        step(40, 100); step(41, 100); step(0, 480);
        total++; if (in_cell !== 1'b0) begin bad++; $display("FAIL reset_in_cell: got %0h expected 0", in_cell); end
        total++; if (rom_address !== 11'd0) begin bad++; $display("FAIL reset_rom_address: got %0d expected 0", rom_address); end
        total++; if (sprite_sel !== 2'b00) begin bad++; $display("FAIL reset_sprite_sel: got %0b expected 00", sprite_sel); end
        total++; if (blank_out !== 1'b0) begin bad++; $display("FAIL reset_blank_out: got %0h expected 0", blank_out); end
        reset_n = 1'b1;
    endtask

    task automatic test_first_cell;
        pattern = 64'h0001_0000_0000_0001; playhead = 4'd0;
        step(0, 480);
        frame_to(100);
        total++; if (ic_a[40] !== 1'b1) begin bad++; $display("FAIL first_in_cell: got %0h expected 1", ic_a[40]); end
        total++; if (ra_a[40] !== 11'd0) begin bad++; $display("FAIL first_addr: got %0d expected 0", ra_a[40]); end
        total++; if (ss_a[40] !== 2'b11) begin bad++; $display("FAIL first_sel: got %0b expected 11", ss_a[40]); end
        total++; if (ra_a[41] !== 11'd1) begin bad++; $display("FAIL second_px_addr: got %0d expected 1", ra_a[41]); end
        total++; if (bo_a[40] !== 1'b1) begin bad++; $display("FAIL blank_out: got %0h expected 1", bo_a[40]); end
        total++; if (ic_a[75] !== 1'b0 || ra_a[75] !== 11'd0) begin bad++; $display("FAIL gap_col: got ic=%0h addr=%0d expected ic=0 addr=0", ic_a[75], ra_a[75]); end
        total++; if (ic_a[76] !== 1'b1 || ra_a[76] !== 11'd0 || ss_a[76] !== 2'b00) begin bad++; $display("FAIL col1: got ic=%0h addr=%0d sel=%0b expected ic=1 addr=0 sel=00", ic_a[76], ra_a[76], ss_a[76]); end
    endtask

    task automatic test_corner;
        frame_to(134);
        total++; if (ra_a[74] !== 11'd1224 || ic_a[74] !== 1'b1) begin bad++; $display("FAIL max_addr: got addr=%0d ic=%0h expected addr=1224 ic=1", ra_a[74], ic_a[74]); end
        total++; if (ss_a[74] !== 2'b11) begin bad++; $display("FAIL max_addr_sel: got %0b expected 11", ss_a[74]); end
        frame_to(135);
        total++; if (ic_a[40] !== 1'b0) begin bad++; $display("FAIL gap_row: got %0h expected 0", ic_a[40]); end
        frame_to(242);
        total++; if (ic_a[614] !== 1'b1 || ra_a[614] !== 11'd1224) begin bad++; $display("FAIL last_cell: got ic=%0h addr=%0d expected ic=1 addr=1224", ic_a[614], ra_a[614]); end
        total++; if (ss_a[614] !== 2'b00) begin bad++; $display("FAIL last_cell_sel: got %0b expected 00", ss_a[614]); end
        total++; if (ic_a[615] !== 1'b0 || ic_a[616] !== 1'b0) begin bad++; $display("FAIL past_grid: got %0h%0h expected 00", ic_a[615], ic_a[616]); end
        total++; if (ic_a[40] !== 1'b1 || ss_a[40] !== 2'b11) begin bad++; $display("FAIL row3_col0: got ic=%0h sel=%0b expected ic=1 sel=11", ic_a[40], ss_a[40]); end
    endtask

    task automatic test_blank;
        blank = 1'b0;
        frame_to(100);
        total++; if (ic_a[40] !== 1'b0 || ra_a[40] !== 11'd0 || ss_a[40] !== 2'b00) begin bad++; $display("FAIL blank_forces_off: got ic=%0h addr=%0d sel=%0b expected 0 0 00", ic_a[40], ra_a[40], ss_a[40]); end
        total++; if (bo_a[40] !== 1'b0) begin bad++; $display("FAIL blank_out_low: got %0h expected 0", bo_a[40]); end
        blank = 1'b1;
    endtask

    task automatic test_pattern_change;
        fast_lines(100, 200);
        pattern = 64'h8000_0000_0000_0000; playhead = 4'd15;
        fast_lines(200, 210);
        run_line(210);
        total++; if (ss_a[40] !== 2'b11) begin bad++; $display("FAIL old_frame_col0: got %0b expected 11", ss_a[40]); end
        total++; if (ss_a[614] !== 2'b00) begin bad++; $display("FAIL old_frame_col15: got %0b expected 00", ss_a[614]); end
        step(0, 480);
        frame_to(210);
        total++; if (ss_a[40] !== 2'b00 || ra_a[40] !== 11'd70) begin bad++; $display("FAIL new_col0: got sel=%0b addr=%0d expected sel=00 addr=70", ss_a[40], ra_a[40]); end
        total++; if (ss_a[614] !== 2'b11) begin bad++; $display("FAIL new_col15: got %0b expected 11", ss_a[614]); end
        total++; if (ss_a[580] !== 2'b11) begin bad++; $display("FAIL new_col15_left: got %0b expected 11", ss_a[580]); end
        total++; if (ic8_a[292] !== 1'b1 || ss8_a[292] !== 2'b00) begin bad++; $display("FAIL cols8_no_hl: got ic=%0h sel=%0b expected ic=1 sel=00", ic8_a[292], ss8_a[292]); end
        total++; if (ic8_a[328] !== 1'b0) begin bad++; $display("FAIL cols8_end: got %0h expected 0", ic8_a[328]); end
    endtask

    task automatic test_reset_midframe;
        int hits;
        pattern = 64'h1; playhead = 4'd0;
        fast_lines(100, 150);
        reset_n = 1'b0;
        step(40, 150); step(41, 150); step(42, 150);
        total++; if (in_cell !== 1'b0) begin bad++; $display("FAIL midreset_in_cell: got %0h expected 0", in_cell); end
        reset_n = 1'b1;
        fast_lines(151, 160);
        run_line(160);
        hits = 0;
        for (int x = 40; x <= 620; x++) if (ic_a[x] !== 1'b0) hits++;
        total++; if (hits !== 0) begin bad++; $display("FAIL midreset_no_cells: got %0d cells expected 0", hits); end
        step(0, 480);
        frame_to(100);
        total++; if (ic_a[40] !== 1'b1 || ss_a[40] !== 2'b11) begin bad++; $display("FAIL resume: got ic=%0h sel=%0b expected ic=1 sel=11", ic_a[40], ss_a[40]); end
        total++; if (ss_a[76] !== 2'b00) begin bad++; $display("FAIL resume_col1: got %0b expected 00", ss_a[76]); end
    endtask

    initial begin
        reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b1;
        pattern = '0; playhead = '0;
        test_reset;
        test_first_cell;
        test_corner;
        test_blank;
        test_pattern_change;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
